// File: rtl/j1_io_hub_pkg.sv
// Shared constants and types for the j1 I/O hub.
// Address-bit map, status/pending bit positions, RX intake FSM states.
package io_hub_pkg;

    localparam int A_RX    = 12;
    localparam int A_STAT  = 13;
    localparam int A_TICKS = 14;
    localparam int A_IRQ   = 15;

    localparam int P_IN  = 0;
    localparam int P_OUT = 1;
    localparam int P_DIR = 2;

    localparam int ST_TXRDY = 0;
    localparam int ST_AVAIL = 1;
    localparam int ST_FULL  = 2;
    localparam int ST_OVR   = 3;

    localparam int ST_OVR_CLR = 2;

    localparam int PD_TICK = 0;
    localparam int PD_RX   = 1;
    localparam int PD_OVR  = 2;

    localparam int IRQ_CLR_TICK = 8;

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } rx_state_t;

    function automatic int port_bit(input int k, input int off);
        return 4 * k + off;
    endfunction

endpackage

// File: rtl/j1_io_hub_if.sv
// j1 core I/O bus: one-cycle read/write strobes, one-hot address.
// The core is the master; the hub answers with combinational read data.
interface j1_io_hub_if #(
    parameter int WIDTH = 32
);
    logic             io_rd;
    logic             io_wr;
    logic [15:0]      io_addr;
    logic [WIDTH-1:0] io_dout;
    logic [WIDTH-1:0] io_din;

    modport master (
        output io_rd,
        output io_wr,
        output io_addr,
        output io_dout,
        input  io_din
    );

    modport slave (
        input  io_rd,
        input  io_wr,
        input  io_addr,
        input  io_dout,
        output io_din
    );
endinterface

// File: rtl/j1_io_hub_rx_fifo.sv
// Synchronous FIFO buffering received UART bytes.
// Push and pop in one cycle both take effect, including when full.
module io_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset, the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (!resetq) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/j1_io_hub.sv
// j1 memory-mapped I/O hub: GPIO ports, ticks timer, buffered UART RX, IRQs.
// Define IO_PIN_SYNC_EN to put a 2-flop synchronizer on port_in.
module j1_io_hub
    import io_hub_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NPORTS  = 3,
    parameter int RXDEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetq,
    j1_io_hub_if.slave               bus,
    output logic                     interrupt_request,
    output logic                     uart_wr,
    output logic [7:0]               uart_w,
    input  logic                     uart_busy,
    output logic                     uart_rd,
    input  logic                     uart_valid,
    input  logic [7:0]               uart_data,
    input  logic [NPORTS*WIDTH-1:0]  port_in,
    output logic [NPORTS*WIDTH-1:0]  port_out,
    output logic [NPORTS*WIDTH-1:0]  port_dir
);
    localparam int CW = $clog2(RXDEPTH) + 1;

    logic [15:0]             a;
    logic                    wr;
    logic [WIDTH-1:0]        wdata;
    logic [WIDTH-1:0]        rdata;
    logic [NPORTS*WIDTH-1:0] pin_q;

    logic [WIDTH-1:0]        ticks;
    logic                    tick_wrap;
    logic                    tick_wr;
    logic                    tick_flag;
    logic [7:0]              mask;
    logic [7:0]              pending;
    logic                    overrun;
    logic                    ovr_set;
    logic                    ovr_clr;
    logic [3:0]              status;

    rx_state_t               state_q;
    rx_state_t               state_d;
    logic                    rx_push;
    logic                    rx_pop;
    logic [7:0]              rx_head;
    logic                    rx_full;
    logic                    rx_empty;
    logic [CW-1:0]           rx_count;

    logic                    unused_ok;

    assign a       = bus.io_addr;
    assign wr      = bus.io_wr;
    assign wdata   = bus.io_dout;
    assign uart_wr = wr & a[A_RX];
    assign uart_w  = wdata[7:0];
    assign rx_pop  = bus.io_rd & a[A_RX];

    assign unused_ok = ^{rx_count, a[11], a[7], a[3]};

`ifdef IO_PIN_SYNC_EN
    logic [NPORTS*WIDTH-1:0] pin_s1;
    logic [NPORTS*WIDTH-1:0] pin_s2;

    // Two-stage synchronizer for asynchronous board pins.
    always_ff @(posedge clk) begin
        if (!resetq) begin
            pin_s1 <= '0;
            pin_s2 <= '0;
        end else begin
            pin_s1 <= port_in;
            pin_s2 <= pin_s1;
        end
    end

    assign pin_q = pin_s2;
`else
    assign pin_q = port_in;
`endif

    // GPIO output and direction registers; every selected port is written.
    always_ff @(posedge clk) begin
        if (!resetq) begin
            port_out <= '0;
            port_dir <= '0;
        end else if (wr) begin
            for (int k = 0; k < NPORTS; k++) begin
                if (a[port_bit(k, P_OUT)]) begin
                    port_out[k*WIDTH +: WIDTH] <= wdata;
                end
                if (a[port_bit(k, P_DIR)]) begin
                    port_dir[k*WIDTH +: WIDTH] <= wdata;
                end
            end
        end
    end

    assign tick_wr   = wr & a[A_TICKS];
    assign tick_wrap = &ticks;

    // Free-running ticks counter; a bus write reloads it.
    always_ff @(posedge clk) begin
        if (!resetq) begin
            ticks <= '0;
        end else if (tick_wr) begin
            ticks <= wdata;
        end else begin
            ticks <= ticks + 1'b1;
        end
    end

    // Sticky overflow flag; a reload in the wrap cycle suppresses it,
    // and a new overflow wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!resetq) begin
            tick_flag <= 1'b0;
        end else if (tick_wrap && !tick_wr) begin
            tick_flag <= 1'b1;
        end else if (wr && a[A_IRQ] && wdata[IRQ_CLR_TICK]) begin
            tick_flag <= 1'b0;
        end
    end

    // Interrupt mask register.
    always_ff @(posedge clk) begin
        if (!resetq) begin
            mask <= '0;
        end else if (wr && a[A_IRQ]) begin
            mask <= wdata[7:0];
        end
    end

    assign ovr_clr = wr & a[A_STAT] & wdata[ST_OVR_CLR];

    // Overrun: a byte was offered while the FIFO was full.
    always_ff @(posedge clk) begin
        if (!resetq) begin
            overrun <= 1'b0;
        end else if (ovr_set) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

    // Pending sources: sticky tick flag, RX level, overrun level.
    always_comb begin
        pending          = '0;
        pending[PD_TICK] = tick_flag;
        pending[PD_RX]   = ~rx_empty;
        pending[PD_OVR]  = overrun;
    end

    // Registered interrupt request to the core.
    always_ff @(posedge clk) begin
        if (!resetq) begin
            interrupt_request <= 1'b0;
        end else begin
            interrupt_request <= |(pending[2:0] & mask[2:0]);
        end
    end

    // RX intake state register.
    always_ff @(posedge clk) begin
        if (!resetq) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // RX intake: take one byte then idle one cycle so the UART can
    // drop valid; refuse and flag overrun while the FIFO is full.
    always_comb begin
        state_d = state_q;
        rx_push = 1'b0;
        ovr_set = 1'b0;
        if (resetq) begin
            unique case (state_q)
                S_IDLE: begin
                    if (uart_valid && !rx_full) begin
                        rx_push = 1'b1;
                        state_d = S_HOLD;
                    end else if (uart_valid) begin
                        ovr_set = 1'b1;
                    end
                end
                S_HOLD: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign uart_rd = rx_push;

    io_rx_fifo #(
        .WIDTH (8),
        .DEPTH (RXDEPTH)
    ) u_rx_fifo (
        .clk    (clk),
        .resetq (resetq),
        .push   (rx_push),
        .pop    (rx_pop),
        .din    (uart_data),
        .dout   (rx_head),
        .full   (rx_full),
        .empty  (rx_empty),
        .count  (rx_count)
    );

    always_comb begin
        status           = '0;
        status[ST_TXRDY] = ~uart_busy;
        status[ST_AVAIL] = ~rx_empty;
        status[ST_FULL]  = rx_full;
        status[ST_OVR]   = overrun;
    end

    // Read mux: all selected registers are ORed together.
    always_comb begin
        rdata = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (a[port_bit(k, P_IN)]) begin
                rdata = rdata | pin_q[k*WIDTH +: WIDTH];
            end
            if (a[port_bit(k, P_OUT)]) begin
                rdata = rdata | port_out[k*WIDTH +: WIDTH];
            end
            if (a[port_bit(k, P_DIR)]) begin
                rdata = rdata | port_dir[k*WIDTH +: WIDTH];
            end
        end
        if (a[A_RX] && !rx_empty) begin
            rdata[7:0] = rdata[7:0] | rx_head;
        end
        if (a[A_STAT]) begin
            rdata[3:0] = rdata[3:0] | status;
        end
        if (a[A_TICKS]) begin
            rdata = rdata | ticks;
        end
        if (a[A_IRQ]) begin
            rdata[15:0] = rdata[15:0] | {pending, mask};
        end
    end

    assign bus.io_din = rdata;

endmodule

// File: tb/tb_j1_io_hub.sv
// Directed self-checking bench for j1_io_hub (WIDTH 32, NPORTS 3, RXDEPTH 8).
// Honours IO_PIN_SYNC_EN for the pin-latency check.
module tb_j1_io_hub;

    logic        clk;
    logic        resetq;
    logic        interrupt_request;
    logic        uart_wr;
    logic [7:0]  uart_w;
    logic        uart_busy;
    logic        uart_rd;
    logic        uart_valid;
    logic [7:0]  uart_data;
    logic [95:0] port_in;
    logic [95:0] port_out;
    logic [95:0] port_dir;

    int n_chk;
    int n_err;

    j1_io_hub_if #(.WIDTH(32)) bus ();

    j1_io_hub #(
        .WIDTH   (32),
        .NPORTS  (3),
        .RXDEPTH (8)
    ) dut (
        .clk               (clk),
        .resetq            (resetq),
        .bus               (bus),
        .interrupt_request (interrupt_request),
        .uart_wr           (uart_wr),
        .uart_w            (uart_w),
        .uart_busy         (uart_busy),
        .uart_rd           (uart_rd),
        .uart_valid        (uart_valid),
        .uart_data         (uart_data),
        .port_in           (port_in),
        .port_out          (port_out),
        .port_dir          (port_dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [31:0] data);
        bus.io_addr = addr;
        bus.io_dout = data;
        bus.io_wr   = 1'b1;
        step();
        bus.io_wr   = 1'b0;
        bus.io_addr = '0;
        bus.io_dout = '0;
    endtask

    task automatic peek(input logic [15:0] addr, input logic [31:0] exp,
                        input string tag);
        bus.io_addr = addr;
        #1;
        chk(tag, bus.io_din, exp);
        bus.io_addr = '0;
    endtask

    task automatic pop(input logic [31:0] exp, input string tag);
        bus.io_addr = 16'h1000;
        bus.io_rd   = 1'b1;
        #1;
        chk(tag, bus.io_din, exp);
        step();
        bus.io_rd   = 1'b0;
        bus.io_addr = '0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        resetq      = 1'b0;
        uart_busy   = 1'b0;
        uart_valid  = 1'b0;
        uart_data   = '0;
        bus.io_rd   = 1'b0;
        bus.io_wr   = 1'b0;
        bus.io_addr = '0;
        bus.io_dout = '0;
        port_in     = {32'hC0DE0003, 32'hBEEF0002, 32'h0000A5A4};

        // reset state
        step(); step(); step();
        chk("rst_out", port_out[31:0], 32'h0);
        chk("rst_dir", port_dir[31:0], 32'h0);
        chk("rst_irq", {31'h0, interrupt_request}, 32'h0);
        chk("rst_uart_rd", {31'h0, uart_rd}, 32'h0);
        peek(16'h4000, 32'h0, "rst_ticks");
        peek(16'h2000, 32'h1, "rst_status");
        resetq = 1'b1;

        // GPIO
        wr(16'h0004, 32'h0000FFFF);
        wr(16'h0002, 32'h12345678);
        chk("gpio_dir0", port_dir[31:0], 32'h0000FFFF);
        chk("gpio_out0", port_out[31:0], 32'h12345678);
        peek(16'h0006, 32'h1234FFFF, "gpio_or_rd");
        peek(16'h0001, 32'h0000A5A4, "gpio_in0");
        peek(16'h0011, 32'hBEEFA5A6, "gpio_in01_or");
        wr(16'h0220, 32'hCAFEF00D);
        chk("gpio_out1", port_out[63:32], 32'hCAFEF00D);
        chk("gpio_out2", port_out[95:64], 32'hCAFEF00D);
        chk("gpio_out0_kept", port_out[31:0], 32'h12345678);
        peek(16'h0008, 32'h0, "unused_bit");

        // UART TX strobe
        bus.io_addr = 16'h1000;
        bus.io_dout = 32'h000001A5;
        bus.io_wr   = 1'b1;
        #1;
        chk("uart_wr", {31'h0, uart_wr}, 32'h1);
        chk("uart_w", {24'h0, uart_w}, 32'hA5);
        step();
        bus.io_wr   = 1'b0;
        bus.io_addr = '0;
        #1;
        chk("uart_wr_off", {31'h0, uart_wr}, 32'h0);

        // RX intake: 8 bytes, pulses 2 cycles apart
        for (int i = 0; i < 8; i++) begin
            uart_valid = 1'b1;
            uart_data  = 8'h41 + 8'(i);
            #1;
            chk($sformatf("rx_rd_%0d", i), {31'h0, uart_rd}, 32'h1);
            step();
            uart_valid = 1'b0;
            #1;
            chk($sformatf("rx_hold_%0d", i), {31'h0, uart_rd}, 32'h0);
            step();
        end
        peek(16'h2000, 32'h7, "status_full");

        // full FIFO with a waiting byte
        uart_valid = 1'b1;
        uart_data  = 8'h49;
        #1;
        chk("full_no_rd", {31'h0, uart_rd}, 32'h0);
        step();
        peek(16'h2000, 32'hF, "status_ovr");
        pop(32'h41, "pop_41");
        chk("refill_rd", {31'h0, uart_rd}, 32'h1);
        step();
        uart_valid = 1'b0;
        peek(16'h2000, 32'hF, "refill_full");
        wr(16'h2000, 32'h4);
        peek(16'h2000, 32'h7, "ovr_clear");
        uart_busy = 1'b1;
        peek(16'h2000, 32'h6, "tx_busy");
        uart_busy = 1'b0;
        for (int i = 1; i < 9; i++) begin
            pop(32'h41 + 32'(i), $sformatf("pop_%0d", i));
        end
        pop(32'h0, "pop_empty");
        peek(16'h2000, 32'h1, "status_empty");

        // ticks overflow interrupt
        wr(16'h8000, 32'h1);
        wr(16'h4000, 32'hFFFFFFFD);
        chk("irq_e0", {31'h0, interrupt_request}, 32'h0);
        step();
        chk("irq_e1", {31'h0, interrupt_request}, 32'h0);
        step();
        chk("irq_e2", {31'h0, interrupt_request}, 32'h0);
        step();
        chk("irq_e3", {31'h0, interrupt_request}, 32'h0);
        step();
        chk("irq_e4", {31'h0, interrupt_request}, 32'h1);
        peek(16'h4000, 32'h1, "ticks_wrapped");
        peek(16'h8000, 32'h0101, "irq_ctl_rd");
        wr(16'h8000, 32'h100);
        peek(16'h8000, 32'h0, "pend_cleared");
        step();
        chk("irq_low", {31'h0, interrupt_request}, 32'h0);

        // reload in the overflow cycle
        wr(16'h4000, 32'hFFFFFFFE);
        step();
        wr(16'h4000, 32'h55);
        peek(16'h4000, 32'h55, "ticks_reload");
        peek(16'h8000, 32'h0, "no_wrap_flag");
        step();
        peek(16'h4000, 32'h56, "ticks_inc");

        // overflow beats a same-cycle clear
        wr(16'h4000, 32'hFFFFFFFE);
        step();
        wr(16'h8000, 32'h104);
        peek(16'h8000, 32'h0104, "set_beats_clr");
        wr(16'h8000, 32'h100);
        peek(16'h8000, 32'h0, "clr_after");

        // pin input latency
        port_in[0] = 1'b1;
`ifdef IO_PIN_SYNC_EN
        peek(16'h0001, 32'h0000A5A4, "pin_sync_e0");
        step();
        peek(16'h0001, 32'h0000A5A4, "pin_sync_e1");
        step();
        peek(16'h0001, 32'h0000A5A5, "pin_sync_e2");
`else
        peek(16'h0001, 32'h0000A5A5, "pin_direct");
`endif

        // reset mid-operation discards the FIFO
        uart_valid = 1'b1;
        uart_data  = 8'h77;
        step();
        uart_valid = 1'b0;
        peek(16'h2000, 32'h3, "pre_rst_avail");
        resetq = 1'b0;
        step();
        resetq = 1'b1;
        peek(16'h2000, 32'h1, "mid_rst_empty");
        chk("mid_rst_out", port_out[31:0], 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
